// File: rtl/spi_host_router.sv
// spi_host_router: host byte-stream <-> multi-slave SPI FIFO packet router.
// RX parses [SYNC][DEST][LEN][payload] into one-hot writes to the SPI master FIFO.
// TX drains pending slave read-back data as [SYNC][DEST][LEN][data] frames.
// Build macro RSP_CHECKSUM_EN: when defined, each TX frame ends with an XOR checksum byte.

module spi_host_router #(
  parameter int          N_SLAVES  = 3,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5,
  parameter logic [15:0] TIMEOUT   = 16'd50000
) (
  input  logic                sys_clk,
  input  logic                n_rst,
  input  logic [7:0]          rx_data,
  input  logic                rx_valid,
  output logic                rx_ready,
  output logic [7:0]          tx_data,
  output logic                tx_valid,
  input  logic                tx_ready,
  output logic [7:0]          m_din,
  output logic [N_SLAVES-1:0] m_wrreq_bus,
  output logic [N_SLAVES-1:0] s_rdreq_bus,
  input  logic [7:0]          s_dout,
  input  logic [N_SLAVES-1:0] have_msg_bus,
  input  logic [7:0]          len,
  output logic                err_dest,
  output logic                err_timeout
);

  localparam logic [7:0]          NS8 = 8'(N_SLAVES);
  localparam logic [N_SLAVES-1:0] ONE = N_SLAVES'(1);

  typedef enum logic [2:0] {R_IDLE, R_DEST, R_LEN, R_DATA, R_DROP} rxState_t;
  typedef enum logic [2:0] {
    T_IDLE, T_SYNC, T_DEST, T_LEN, T_RD, T_CAP, T_DATA
`ifdef RSP_CHECKSUM_EN
    , T_CSUM
`endif
  } txState_t;

  rxState_t r_rxState, w_rxNext;
  txState_t r_txState, w_txNext;

  logic [7:0]          r_rxDest, r_rxCnt, r_mDin;
  logic                r_rxDrop, r_errDest, r_errTimeout;
  logic [15:0]         r_idleCnt;
  logic [N_SLAVES-1:0] r_mWr;
  logic                w_rxAcc, w_destBad, w_timeout, w_wrEn, w_errDest;

  logic [7:0]          r_txDest, r_txCnt, r_txData;
  logic                r_txValid;
  logic [7:0]          w_pickIdx, w_lenEff;
  logic                w_pickFound, w_txHsk, w_txLast;
`ifdef RSP_CHECKSUM_EN
  logic [7:0]          r_csum;
`endif

  assign rx_ready    = 1'b1;
  assign w_rxAcc     = rx_valid;
  assign w_destBad   = (rx_data >= NS8);
  assign w_timeout   = (r_rxState != R_IDLE) && !w_rxAcc && (r_idleCnt == TIMEOUT - 16'd1);
  assign m_din       = r_mDin;
  assign m_wrreq_bus = r_mWr;
  assign err_dest    = r_errDest;
  assign err_timeout = r_errTimeout;

  assign tx_data     = r_txData;
  assign tx_valid    = r_txValid;
  assign w_txHsk     = r_txValid && tx_ready;
  assign w_txLast    = (r_txCnt == 8'd1);
  assign w_pickFound = |have_msg_bus;
  assign w_lenEff    = (len == 8'd0) ? 8'hFF : len;

  // RX state register
  always_ff @(posedge sys_clk or negedge n_rst) begin
    if (!n_rst) r_rxState <= R_IDLE;
    else        r_rxState <= w_rxNext;
  end

  // RX next state: one step per accepted byte, timeout forces a return to idle
  always_comb begin
    w_rxNext = r_rxState;
    if (w_timeout) begin
      w_rxNext = R_IDLE;
    end else if (w_rxAcc) begin
      case (r_rxState)
        R_IDLE:         if (rx_data == SYNC_BYTE) w_rxNext = R_DEST;
        R_DEST:         w_rxNext = R_LEN;
        R_LEN:          if (rx_data == 8'd0) w_rxNext = R_IDLE;
                        else if (r_rxDrop)   w_rxNext = R_DROP;
                        else                 w_rxNext = R_DATA;
        R_DATA, R_DROP: if (r_rxCnt == 8'd1) w_rxNext = R_IDLE;
        default:        w_rxNext = R_IDLE;
      endcase
    end
  end

  // RX output decode: payload write request and bad-destination detection
  always_comb begin
    w_wrEn    = (r_rxState == R_DATA) && w_rxAcc;
    w_errDest = (r_rxState == R_DEST) && w_rxAcc && w_destBad;
  end

  // RX datapath: latched header fields, inter-byte idle counter, registered outputs
  always_ff @(posedge sys_clk or negedge n_rst) begin
    if (!n_rst) begin
      r_rxDest     <= '0;
      r_rxCnt      <= '0;
      r_rxDrop     <= 1'b0;
      r_idleCnt    <= '0;
      r_mDin       <= '0;
      r_mWr        <= '0;
      r_errDest    <= 1'b0;
      r_errTimeout <= 1'b0;
    end else begin
      if (w_rxAcc || w_timeout || r_rxState == R_IDLE) r_idleCnt <= '0;
      else                                             r_idleCnt <= r_idleCnt + 16'd1;
      if (w_rxAcc && r_rxState == R_DEST) begin
        r_rxDest <= rx_data;
        r_rxDrop <= w_destBad;
      end
      if (w_rxAcc && r_rxState == R_LEN) r_rxCnt <= rx_data;
      else if (w_rxAcc && (r_rxState == R_DATA || r_rxState == R_DROP)) r_rxCnt <= r_rxCnt - 8'd1;
      if (w_wrEn) r_mDin <= rx_data;
      r_mWr        <= w_wrEn ? (ONE << r_rxDest) : '0;
      r_errDest    <= w_errDest;
      r_errTimeout <= w_timeout;
    end
  end

  // TX source selection: lowest-numbered slave with pending data wins
  always_comb begin
    w_pickIdx = '0;
    for (int i = N_SLAVES - 1; i >= 0; i--) begin
      if (have_msg_bus[i]) w_pickIdx = 8'(i);
    end
  end

  // TX state register
  always_ff @(posedge sys_clk or negedge n_rst) begin
    if (!n_rst) r_txState <= T_IDLE;
    else        r_txState <= w_txNext;
  end

  // TX next state: header bytes and data bytes advance on host handshake
  always_comb begin
    w_txNext = r_txState;
    case (r_txState)
      T_IDLE: if (w_pickFound) w_txNext = T_SYNC;
      T_SYNC: if (w_txHsk) w_txNext = T_DEST;
      T_DEST: if (w_txHsk) w_txNext = T_LEN;
      T_LEN:  if (w_txHsk) w_txNext = T_RD;
      T_RD:   w_txNext = T_CAP;
      T_CAP:  w_txNext = T_DATA;
      T_DATA: if (w_txHsk) begin
`ifdef RSP_CHECKSUM_EN
                w_txNext = w_txLast ? T_CSUM : T_RD;
`else
                w_txNext = w_txLast ? T_IDLE : T_RD;
`endif
              end
`ifdef RSP_CHECKSUM_EN
      T_CSUM: if (w_txHsk) w_txNext = T_IDLE;
`endif
      default: w_txNext = T_IDLE;
    endcase
  end

  // TX output decode: single-cycle read strobe to the latched slave
  always_comb begin
    s_rdreq_bus = (r_txState == T_RD) ? (ONE << r_txDest) : '0;
  end

  // TX datapath: latched dest/count, presented byte and its valid flag
  always_ff @(posedge sys_clk or negedge n_rst) begin
    if (!n_rst) begin
      r_txDest  <= '0;
      r_txCnt   <= '0;
      r_txData  <= '0;
      r_txValid <= 1'b0;
`ifdef RSP_CHECKSUM_EN
      r_csum    <= '0;
`endif
    end else begin
      case (r_txState)
        T_IDLE: if (w_pickFound) begin
                  r_txDest  <= w_pickIdx;
                  r_txCnt   <= w_lenEff;
                  r_txData  <= SYNC_BYTE;
                  r_txValid <= 1'b1;
`ifdef RSP_CHECKSUM_EN
                  r_csum    <= w_pickIdx ^ w_lenEff;
`endif
                end
        T_SYNC: if (w_txHsk) r_txData <= r_txDest;
        T_DEST: if (w_txHsk) r_txData <= r_txCnt;
        T_LEN:  if (w_txHsk) r_txValid <= 1'b0;
        T_CAP:  begin
                  r_txData  <= s_dout;
                  r_txValid <= 1'b1;
`ifdef RSP_CHECKSUM_EN
                  r_csum    <= r_csum ^ s_dout;
`endif
                end
        T_DATA: if (w_txHsk) begin
                  r_txCnt <= r_txCnt - 8'd1;
`ifdef RSP_CHECKSUM_EN
                  if (w_txLast) r_txData  <= r_csum;
                  else          r_txValid <= 1'b0;
`else
                  r_txValid <= 1'b0;
`endif
                end
`ifdef RSP_CHECKSUM_EN
        T_CSUM: if (w_txHsk) r_txValid <= 1'b0;
`endif
        default: ;
      endcase
    end
  end

endmodule
